program_loader: RTL and testbench



---
 rtl/program_loader.sv | 175 +++++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Byte-stream program loader into unified RAM, then fetch sequencer.
//            Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              fetch_next,
  output logic [ADDR_W-1:0] fetch_address,
  output logic              run,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;     // lower three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic              w_xfer;
  logic [15:0]       w_hdr_count;
  logic              w_hdr_bad;
  logic [15:0]       w_idx_next;
  logic [ADDR_W-1:0] w_last_fetch;

  assign w_xfer       = in_valid && in_ready;
  assign w_hdr_count  = {in_data, r_count[7:0]};
  assign w_hdr_bad    = (w_hdr_count == 16'd0) || ({16'd0, w_hdr_count} > MAX_WORDS);
  assign w_idx_next   = r_word_idx + 16'd1;
  assign w_last_fetch = BASE_ADDR + ADDR_W'(r_count - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_count       <= 16'd0;
      r_word_idx    <= 16'd0;
      r_byte_idx    <= 2'd0;
      r_word        <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      r_xor         <= 8'd0;
`endif
      in_ready      <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= BASE_ADDR;
      ram_wdata     <= 32'd0;
      fetch_address <= BASE_ADDR;
      run           <= 1'b0;
      err           <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state       <= S_HDR0;
            in_ready      <= 1'b1;
            run           <= 1'b0;
            err           <= 1'b0;
            r_count       <= 16'd0;
            r_word_idx    <= 16'd0;
            r_byte_idx    <= 2'd0;
            r_word        <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            r_xor         <= 8'd0;
`endif
            fetch_address <= BASE_ADDR;
          end else if (r_state == S_DONE && fetch_next) begin
            fetch_address <= (fetch_address == w_last_fetch) ? BASE_ADDR
                                                             : fetch_address + 1'b1;
          end
        end
        S_HDR0: begin
          if (w_xfer) begin
            r_count[7:0] <= in_data;
            r_state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_count <= w_hdr_count;
            if (w_hdr_bad) begin
              r_state  <= S_ERROR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ in_data;
`endif
            r_byte_idx <= r_byte_idx + 2'd1;
            r_word     <= {in_data, r_word[23:8]};
            if (r_byte_idx == 2'd3) begin
              r_state   <= S_WRITE;
              in_ready  <= 1'b0;
              ram_we    <= 1'b1;
              ram_addr  <= BASE_ADDR + ADDR_W'(r_word_idx);
              ram_wdata <= {in_data, r_word};
            end
          end
        end
        S_WRITE: begin
          r_word_idx <= w_idx_next;
          if (w_idx_next == r_count) begin
`ifdef LOADER_CHECKSUM_EN
            r_state  <= S_CHK;
            in_ready <= 1'b1;
`else
            r_state       <= S_DONE;
            run           <= 1'b1;
            fetch_address <= BASE_ADDR;
`endif
          end else begin
            r_state  <= S_DATA;
            in_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
            if (in_data == r_xor) begin
              r_state       <= S_DONE;
              run           <= 1'b1;
              fetch_address <= BASE_ADDR;
            end else begin
              r_state <= S_ERROR;
              err     <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader (vector table + random loads).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_program_loader;

  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam int          MAXW   = 256;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'd0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              fetch_next = 1'b0;
  logic [ADDR_W-1:0] fetch_address;
  logic              run;
  logic              err;

  program_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .fetch_next    (fetch_next),
    .fetch_address (fetch_address),
    .run           (run),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int proto_viol = 0;
  bit rnd_mode = 1'b0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // Observed RAM writes plus invariants: no ready during a write, fetch parked until run
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
      if (in_ready) proto_viol++;
    end
    if (reset_n && !run && fetch_address != BASE) proto_viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; fetch_next = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, BASE);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_fetch"}, fetch_address, BASE);
    check({tag, "_run"}, run, 0);
    check({tag, "_err"}, err, 0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = rnd_mode ? int'($urandom_range(0, 3)) : 0;
    n = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      fetch_next = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      if (rnd_mode) fetch_next = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("byte_accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (rnd_mode) fetch_next = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!run && !err && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Reference: a valid load writes word i at BASE+i, then fetch follows BASE + (pulses mod count)
  task automatic do_load(input logic [7:0] lo, input logic [7:0] hi, input bit rnd,
                         input bit exp_ok, input string tag);
    int          cnt;
    int          pulses;
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  x;
    cnt = int'({hi, lo});
    x = 8'd0;
    wr_addr_q.delete();
    wr_data_q.delete();
    proto_viol = 0;
    rnd_mode = rnd;
    pulse_start();
    send_byte(lo);
    send_byte(hi);
    if (exp_ok) begin
      for (int i = 0; i < cnt; i++) begin
        w = $urandom;
        words.push_back(w);
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x);
`endif
    end
    fetch_next = 1'b0;
    settle();
    check({tag, "_run"}, run, exp_ok);
    check({tag, "_err"}, err, !exp_ok);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_ok ? cnt : 0);
    for (int i = 0; i < wr_addr_q.size() && i < words.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr_q[i], BASE + 16'(i));
      check({tag, "_wr_data"}, wr_data_q[i], words[i]);
    end
    check({tag, "_protocol"}, proto_viol, 0);
    if (exp_ok) begin
      pulses = 0;
      for (int j = 0; j < 8; j++) begin
        fetch_next = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (fetch_next) pulses++;
        check({tag, "_fetch"}, fetch_address, BASE + 16'(pulses % cnt));
      end
      fetch_next = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    bit         rnd;
    bit         exp_ok;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h01, 8'h00, 1'b1, 1'b1};
    tbl[1] = '{8'h03, 8'h00, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h05, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 1'b0};
    tbl[5] = '{8'h10, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 8'h01, 1'b1, 1'b1};
    tbl[8] = '{8'h07, 8'h00, 1'b1, 1'b1};

    do_reset("reset");

    // Single word: write one cycle after the 4th byte, run one cycle later
    rnd_mode = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("t1_ram_we", ram_we, 1);
    check("t1_ram_addr", ram_addr, BASE);
    check("t1_ram_wdata", ram_wdata, 32'h12345678);
    check("t1_in_ready_write", in_ready, 0);
    @(negedge clk);
    check("t1_ram_we_drop", ram_we, 0);
    check("t1_wr_count", wr_addr_q.size(), 1);
`ifdef LOADER_CHECKSUM_EN
    check("t1_chk_ready", in_ready, 1);
    check("t1_chk_run", run, 0);
    send_byte(8'h08);
    check("t1_chk_ok_run", run, 1);
    check("t1_chk_ok_err", err, 0);
    check("t1_fetch", fetch_address, BASE);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h09);
    check("t1_chk_bad_err", err, 1);
    check("t1_chk_bad_run", run, 0);
`else
    check("t1_run", run, 1);
    check("t1_err", err, 0);
    check("t1_fetch", fetch_address, BASE);
`endif

    for (int v = 0; v < 9; v++)
      do_load(tbl[v].lo, tbl[v].hi, tbl[v].rnd, tbl[v].exp_ok, $sformatf("vec%0d", v));

    // Reset in the middle of the third word, then a clean reload
    rnd_mode = 1'b0;
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    do_reset("midload");
    do_load(8'h01, 8'h00, 1'b0, 1'b1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
